// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment driver with tear-free frame update, blanking, PWM and dead time.
// Define SEG7_DP_EN to drive the decimal point from dp_mask; otherwise dp stays high.
module seg7_scan_driver #(
    parameter int DIGITS    = 8,
    parameter int SCAN_LOG2 = 17,
    parameter int PWM_BITS  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] data,
    input  logic                load,
    input  logic [DIGITS-1:0]   digit_en,
    input  logic                blank_lz,
    input  logic [PWM_BITS-1:0] bright,
    input  logic [DIGITS-1:0]   dp_mask,
    output logic [6:0]          a2g,
    output logic [DIGITS-1:0]   an,
    output logic                dp
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [SCAN_LOG2-1:0] cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [4*DIGITS-1:0]  pend_q, pend_d, shad_q, shad_d;
    logic [6:0]           a2g_d;
    logic [DIGITS-1:0]    an_d;
    logic [3:0]           nib;
    logic                 frame_end, lit, blank, lz, dp_d;

    always_comb begin
        lz = 1'b1;
        blank = 1'b0;
        // lz accumulates "all nibbles from i upward are zero"; digit 0 is never blanked
        for (int i = DIGITS - 1; i > 0; i--) begin
            lz = lz && shad_q[4*i +: 4] == 4'h0;
            if (IW'(i) == idx_q) blank = blank_lz && lz;
        end
        nib = 4'(shad_q >> {idx_q, 2'b00});
        frame_end = &cnt_q && idx_q == IW'(DIGITS - 1);
        cnt_d = cnt_q + 1'b1;
        idx_d = &cnt_q ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
        pend_d = load ? data : pend_q;
        shad_d = frame_end ? pend_q : shad_q;
        lit = digit_en[idx_q] && cnt_q != '0 && cnt_q[SCAN_LOG2-1 -: PWM_BITS] <= bright && !blank;
        an_d = lit ? ~(DIGITS'(1) << idx_q) : '1;
        a2g_d = lit ? HEX[nib] : 7'h7F;
    end

`ifdef SEG7_DP_EN
    logic [DIGITS-1:0] pdp_q, sdp_q;

    assign dp_d = ~(lit && sdp_q[idx_q]);

    always_ff @(posedge clk) begin
        if (rst) begin
            pdp_q <= '0;
            sdp_q <= '0;
        end else begin
            pdp_q <= load ? dp_mask : pdp_q;
            sdp_q <= frame_end ? pdp_q : sdp_q;
        end
    end
`else
    logic unused_dp_mask;

    assign unused_dp_mask = ^dp_mask;
    assign dp_d = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            pend_q <= '0;
            shad_q <= '0;
            a2g    <= 7'h7F;
            an     <= '1;
            dp     <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            pend_q <= pend_d;
            shad_q <= shad_d;
            a2g    <= a2g_d;
            an     <= an_d;
            dp     <= dp_d;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed and randomized checks against a time-indexed behavioural model.
module tb_seg7_scan_driver;
    logic        clk = 1'b0, rst = 1'b1, load = 1'b0, blank_lz = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  digit_en = '0, dp_mask = '0;
    logic [2:0]  bright = '0;
    logic [6:0]  a2g;
    logic [3:0]  an;
    logic        dp;

    int n_checks = 0, n_fail = 0;
    int n = 0;
    logic [15:0] pend = '0, shad = '0;
    logic [3:0]  pdp = '0, sdp = '0;

    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .SCAN_LOG2(4), .PWM_BITS(3)) dut (
        .clk(clk), .rst(rst), .data(data), .load(load), .digit_en(digit_en),
        .blank_lz(blank_lz), .bright(bright), .dp_mask(dp_mask),
        .a2g(a2g), .an(an), .dp(dp)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // n counts clocks since reset: slot position n%16, digit (n/16)%4, frame n/64
    function automatic logic [11:0] model_out();
        int cnt, idx;
        logic [15:0] rest;
        logic on, dpv;
        cnt = n % 16;
        idx = (n / 16) % 4;
        rest = shad >> (4 * idx);
        on = digit_en[idx] && cnt != 0 && (cnt / 2) <= int'(bright) && !(blank_lz && idx != 0 && rest == 16'h0);
        dpv = 1'b1;
`ifdef SEG7_DP_EN
        dpv = !(on && sdp[idx]);
`endif
        return on ? {dpv, 4'(~(4'b1 << idx)), HEX[rest[3:0]]} : 12'hFFF;
    endfunction

    task automatic step(string tag);
        logic [11:0] e;
        if (rst) begin
            e = 12'hFFF;
            n = 0; pend = '0; shad = '0; pdp = '0; sdp = '0;
        end else begin
            e = model_out();
            if (n % 64 == 63) begin shad = pend; sdp = pdp; end
            if (load) begin pend = data; pdp = dp_mask; end
            n++;
        end
        @(posedge clk);
        #1;
        check(tag, {dp, an, a2g}, e);
    endtask

    task automatic do_load(logic [15:0] d);
        data = d;
        load = 1'b1;
        step("load");
        load = 1'b0;
    endtask

    task automatic goto_frame();
        while (n % 64 != 0) step("sync");
    endtask

    task automatic count_slot(string tag, int exp_n, logic [3:0] exp_an, logic [6:0] exp_seg);
        int c = 0;
        logic [3:0] la = 4'hF;
        logic [6:0] ls = 7'h7F;
        repeat (16) begin
            step(tag);
            if (an !== 4'hF) begin c++; la = an; ls = a2g; end
        end
        check({tag, "_lit"}, c, exp_n);
        check({tag, "_an"}, la, exp_an);
        check({tag, "_seg"}, ls, exp_seg);
    endtask

    initial begin
        int c;
        logic [3:0] la;
        step("rst0");
        step("rst1");
        rst = 1'b0;
        repeat (40) step("idle");

        digit_en = 4'hF; bright = 3'd7;
        do_load(16'h1234);
        goto_frame();
        count_slot("f1_d0", 15, 4'hE, 7'h19);
        count_slot("f1_d1", 15, 4'hD, 7'h30);
        count_slot("f1_d2", 15, 4'hB, 7'h24);
        count_slot("f1_d3", 15, 4'h7, 7'h79);

        count_slot("mf_d0", 15, 4'hE, 7'h19);
        do_load(16'hABCD);
        repeat (15) step("mf");
        count_slot("mf_d2", 15, 4'hB, 7'h24);
        count_slot("mf_d3", 15, 4'h7, 7'h79);
        count_slot("nf_d0", 15, 4'hE, 7'h21);

        blank_lz = 1'b1;
        do_load(16'h0005);
        goto_frame();
        count_slot("lz5_d0", 15, 4'hE, 7'h12);
        count_slot("lz5_d1", 0, 4'hF, 7'h7F);
        count_slot("lz5_d2", 0, 4'hF, 7'h7F);
        count_slot("lz5_d3", 0, 4'hF, 7'h7F);
        do_load(16'h0000);
        goto_frame();
        count_slot("lz0_d0", 15, 4'hE, 7'h40);
        count_slot("lz0_d1", 0, 4'hF, 7'h7F);
        count_slot("lz0_d2", 0, 4'hF, 7'h7F);
        count_slot("lz0_d3", 0, 4'hF, 7'h7F);

        blank_lz = 1'b0;
        do_load(16'h1234);
        goto_frame();
        bright = 3'd0;
        count_slot("br0", 1, 4'hE, 7'h19);
        bright = 3'd3;
        count_slot("br3", 7, 4'hD, 7'h30);
        bright = 3'd7; digit_en = 4'b0101;
        count_slot("en_d2", 15, 4'hB, 7'h24);
        count_slot("en_d3", 0, 4'hF, 7'h7F);
        count_slot("en_d0", 15, 4'hE, 7'h19);
        count_slot("en_d1", 0, 4'hF, 7'h7F);

        digit_en = 4'hF; dp_mask = 4'b0010;
        do_load(16'h1234);
        goto_frame();
        c = 0; la = 4'hF;
        repeat (64) begin
            step("dp");
            if (dp === 1'b0) begin c++; la = an; end
        end
`ifdef SEG7_DP_EN
        check("dp_lit", c, 15);
        check("dp_an", la, 4'hD);
`else
        check("dp_lit", c, 0);
        check("dp_an", la, 4'hF);
`endif

        repeat (3000) begin
            load = ($urandom % 8) == 0;
            data = ($urandom % 3 == 0) ? 16'($urandom % 256) : 16'($urandom);
            dp_mask = 4'($urandom);
            if ($urandom % 64 == 0) begin
                digit_en = 4'($urandom);
                bright = 3'($urandom);
                blank_lz = 1'($urandom);
            end
            step("rand");
        end
        load = 1'b0;

        while (n % 16 != 5) step("pre_rst");
        rst = 1'b1;
        step("rst_mid");
        check("rst_an", an, 4'hF);
        check("rst_seg", a2g, 7'h7F);
        check("rst_dp", dp, 1'b1);
        rst = 1'b0;
        repeat (40) step("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
